// File: rtl/plle2_drp_ctrl.sv
// plle2_drp_ctrl: run-time reconfiguration sequencer for a PLLE2_ADV via DRP.
// Each host entry becomes a read-modify-write of one DRP register while the
// PLL is held in reset. Reset is released after the last entry, and the
// sequence finishes once LOCKED returns.
// Optional build macro: PLLE2_DRP_CTRL_READBACK_EN adds a verify read after
// each write. A mismatch raises ERR_CODE 3.
module plle2_drp_ctrl #(
  parameter int RST_SETUP    = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65536
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [6:0]  REQ_ADDR,
  input  logic [15:0] REQ_MASK,
  input  logic [15:0] REQ_DATA,
  input  logic        REQ_LAST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [1:0]  ERR_CODE,
  output logic [6:0]  DADDR,
  output logic        DEN,
  output logic        DWE,
  output logic [15:0] DI,
  input  logic [15:0] DO,
  input  logic        DRDY,
  output logic        PLL_RST,
  input  logic        LOCKED
);

  localparam int DATA_W  = 16;
  localparam int T_MAX   = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CNT_MAX = (T_MAX > RST_SETUP) ? T_MAX : RST_SETUP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(RST_SETUP - 1);
  localparam logic [CNT_W-1:0] DRDY_LAST  = CNT_W'(DRDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, SETUP, RD, RD_WAIT, WR, WR_WAIT,
`ifdef PLLE2_DRP_CTRL_READBACK_EN
    VERIFY, VERIFY_WAIT,
`endif
    NEXT, LOCK_WAIT
  } state_t;

  // Bits with mask=1 keep the current register value; mask=0 bits take new data.
  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] old,
                                                  input logic [DATA_W-1:0] mask,
                                                  input logic [DATA_W-1:0] data);
    return (old & mask) | (data & ~mask);
  endfunction

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               accept, cnt_clr, cap_rd, fail, lock_ok;
  logic [1:0]         fail_code;
  logic [DATA_W-1:0]  mask_q, data_q;
  logic               last_q, rdy_q, busy_q, done_q, err_q, pll_rst_q;
  logic [1:0]         err_code_q;
  logic [6:0]         addr_q;
  logic [DATA_W-1:0]  di_q;

  assign REQ_READY = rdy_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign ERR_CODE  = err_code_q;
  assign PLL_RST   = pll_rst_q;
  assign DADDR     = addr_q;
  assign DI        = di_q;
`ifdef PLLE2_DRP_CTRL_READBACK_EN
  assign DEN       = (state == RD) || (state == WR) || (state == VERIFY);
`else
  assign DEN       = (state == RD) || (state == WR);
`endif
  assign DWE       = (state == WR);

  // State register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cnt_clr   = 1'b0;
    cap_rd    = 1'b0;
    fail      = 1'b0;
    fail_code = 2'd0;
    lock_ok   = 1'b0;
    unique case (state)
      IDLE: if (REQ_VALID && rdy_q) begin
        accept = 1'b1; cnt_clr = 1'b1; state_nxt = SETUP;
      end
      SETUP: if (cnt == SETUP_LAST) state_nxt = RD;
      RD: begin state_nxt = RD_WAIT; cnt_clr = 1'b1; end
      RD_WAIT: begin
        if (DRDY) begin cap_rd = 1'b1; state_nxt = WR; end
        else if (cnt == DRDY_LAST) begin fail = 1'b1; fail_code = 2'd1; end
      end
      WR: begin state_nxt = WR_WAIT; cnt_clr = 1'b1; end
      WR_WAIT: begin
        if (DRDY) begin
          cnt_clr = 1'b1;
`ifdef PLLE2_DRP_CTRL_READBACK_EN
          state_nxt = VERIFY;
`else
          state_nxt = last_q ? LOCK_WAIT : NEXT;
`endif
        end else if (cnt == DRDY_LAST) begin fail = 1'b1; fail_code = 2'd1; end
      end
`ifdef PLLE2_DRP_CTRL_READBACK_EN
      VERIFY: begin state_nxt = VERIFY_WAIT; cnt_clr = 1'b1; end
      VERIFY_WAIT: begin
        if (DRDY) begin
          cnt_clr = 1'b1;
          if (DO != di_q) begin fail = 1'b1; fail_code = 2'd3; end
          else state_nxt = last_q ? LOCK_WAIT : NEXT;
        end else if (cnt == DRDY_LAST) begin fail = 1'b1; fail_code = 2'd1; end
      end
`endif
      NEXT: if (REQ_VALID && rdy_q) begin accept = 1'b1; state_nxt = RD; end
      LOCK_WAIT: begin
        // The entry cycle (cnt==0) is skipped so a stale LOCKED cannot end the wait.
        if ((cnt != '0) && LOCKED) begin lock_ok = 1'b1; state_nxt = IDLE; end
        else if (cnt == LOCK_LAST) begin fail = 1'b1; fail_code = 2'd2; end
      end
      default: state_nxt = IDLE;
    endcase
    if (fail) state_nxt = IDLE;
  end

  // Shared cycle counter for setup, DRDY and lock timeouts.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)        cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  // Control outputs, status flags and DRP address/data registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      pll_rst_q  <= 1'b0;
      last_q     <= 1'b0;
      addr_q     <= '0;
      di_q       <= '0;
    end else begin
      rdy_q  <= (state_nxt == IDLE) || (state_nxt == NEXT);
      done_q <= fail || lock_ok;
      if (accept) begin
        addr_q <= REQ_ADDR;
        last_q <= REQ_LAST;
      end
      if (accept && (state == IDLE)) begin
        busy_q     <= 1'b1;
        pll_rst_q  <= 1'b1;
        err_q      <= 1'b0;
        err_code_q <= 2'd0;
      end
      if (cap_rd) di_q <= rmw_merge(DO, mask_q, data_q);
      if ((state_nxt == LOCK_WAIT) && (state != LOCK_WAIT)) pll_rst_q <= 1'b0;
      if (lock_ok) busy_q <= 1'b0;
      if (fail) begin
        err_q      <= 1'b1;
        err_code_q <= fail_code;
        pll_rst_q  <= 1'b0;
        busy_q     <= 1'b0;
      end
    end
  end

  // Entry mask/data only matter once a read has returned, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mask_q <= REQ_MASK;
      data_q <= REQ_DATA;
    end
  end

endmodule
